// File: rtl/fetch_sequencer_pkg.sv
// ============================================================================
// fetch_sequencer_pkg
// Shared core definitions: branch codes and fetch controller state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_sequencer_pkg;

    // Branch codes delivered by execute with the resolution pulse
    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_JAL  = 3'b001;
    localparam logic [2:0] BR_JALR = 3'b010;
    localparam logic [2:0] BR_RSVD = 3'b011;
    localparam logic [2:0] BR_BEQ  = 3'b100;
    localparam logic [2:0] BR_BNE  = 3'b101;
    localparam logic [2:0] BR_BLT  = 3'b110;
    localparam logic [2:0] BR_BGE  = 3'b111;

    // Fetch controller states
    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_DRAIN   = 2'd3
    } fetch_state_t;

endpackage : fetch_sequencer_pkg

`default_nettype wire

// File: rtl/fetch_sequencer_next_pc_sel.sv
// ============================================================================
// next_pc_sel
// Combinational next-PC selection from the resolved branch code and flags.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module next_pc_sel
    import fetch_sequencer_pkg::*;
(
    input  logic [2:0]  branch_i,
    input  logic        less_i,
    input  logic        zero_i,
    input  logic [31:0] instr_pc_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] rs1_i,
    output logic [31:0] next_pc_o,
    output logic        taken_o
);

    // Redirect decision and target choice; reserved code behaves as no branch
    always_comb begin
        taken_o   = 1'b0;
        next_pc_o = instr_pc_i + 32'd4;
        case (branch_i)
            BR_JAL:  taken_o = 1'b1;
            BR_JALR: taken_o = 1'b1;
            BR_BEQ:  taken_o = zero_i;
            BR_BNE:  taken_o = ~zero_i;
            BR_BLT:  taken_o = less_i;
            BR_BGE:  taken_o = ~less_i;
            default: taken_o = 1'b0;
        endcase
        if (taken_o) begin
            if (branch_i == BR_JALR) begin
                next_pc_o = (rs1_i + imm_i) & ~32'h1;
            end else begin
                next_pc_o = instr_pc_i + imm_i;
            end
        end
    end

endmodule : next_pc_sel

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// fetch_sequencer
// Multi-cycle instruction fetch and next-PC controller with trap redirect
// and drain of an uncancellable in-flight fetch.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        res_valid,
    input  logic [2:0]  res_branch,
    input  logic        res_less,
    input  logic        res_zero,
    input  logic [31:0] res_imm,
    input  logic [31:0] res_rs1,
    input  logic        trap_valid,
    input  logic [31:0] trap_pc,
    output logic        taken,
    output logic [31:0] retired_cnt
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  addr_q, addr_d;
    logic         req_q, req_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  ipc_q, ipc_d;
    logic         taken_q, taken_d;
    logic [31:0]  ret_q, ret_d;
    logic [31:0]  sel_next_pc;
    logic         sel_taken;
    logic         ack_seen;

    next_pc_sel u_next_pc_sel (
        .branch_i   (res_branch),
        .less_i     (res_less),
        .zero_i     (res_zero),
        .instr_pc_i (ipc_q),
        .imm_i      (res_imm),
        .rs1_i      (res_rs1),
        .next_pc_o  (sel_next_pc),
        .taken_o    (sel_taken)
    );

    // An ack only counts while our request is actually on the bus
    assign ack_seen = req_q & imem_ack;

    // Next-state, PC and output-register computation; traps override last
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        taken_d = 1'b0;
        ret_d   = ret_q;
        case (state_q)
            ST_FETCH: begin
                if (ack_seen) begin
                    instr_d = imem_rdata;
                    ipc_d   = pc_q;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (instr_ready) begin
                    state_d = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                if (res_valid) begin
                    ret_d   = ret_q + 32'd1;
                    pc_d    = sel_next_pc;
                    taken_d = sel_taken;
                    state_d = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (ack_seen) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase

        if (trap_valid) begin
            pc_d    = trap_pc;
            taken_d = 1'b0;
            instr_d = instr_q;
            ipc_d   = ipc_q;
            // A read already on the bus must complete before refetching
            if ((state_q == ST_FETCH || state_q == ST_DRAIN) && req_q && !imem_ack) begin
                state_d = ST_DRAIN;
            end else begin
                state_d = ST_FETCH;
            end
        end

        // Request drops for one cycle after every ack so each fetch is a fresh rise
        req_d  = (state_d == ST_FETCH || state_d == ST_DRAIN) && !ack_seen;
        // Address tracks pc while fetching, but is frozen during a drain
        addr_d = (state_d == ST_FETCH) ? pc_d : addr_q;
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            instr_q <= 32'd0;
            ipc_q   <= 32'd0;
            taken_q <= 1'b0;
            ret_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            taken_q <= taken_d;
            ret_q   <= ret_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = (state_q == ST_ISSUE);
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;
    assign taken       = taken_q;
    assign retired_cnt = ret_q;

endmodule : fetch_sequencer

`default_nettype wire

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle instruction fetch and next-PC controller for the CPU core. It owns the program counter and issues one instruction at a time to the decode/execute stage. It waits for execute to resolve that instruction's branch type and flags, then selects PC+4, PC+imm or rs1+imm as the next fetch address. It also handles asynchronous trap redirects, including the drain of a fetch already in flight.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)

Ports:
- clk  in  1  core clock, all logic on rising edge
- rstn  in  1  asynchronous, active-low reset
- imem_req  out  1  instruction read request
- imem_addr  out  32  fetch address, stable while imem_req=1
- imem_ack  in  1  read data valid this cycle; never in the same cycle imem_req first rises
- imem_rdata  in  32  instruction word, valid with imem_ack
- instr_valid  out  1  instruction offered to decode
- instr  out  32  held instruction word
- instr_pc  out  32  PC of held instruction
- instr_ready  in  1  decode accepts; transfer when instr_valid & instr_ready
- res_valid  in  1  execute has resolved the issued instruction (one-cycle pulse)
- res_branch  in  3  branch code: 000 none, 001 jal, 010 jalr, 100 beq, 101 bne, 110 blt, 111 bge, 011 reserved
- res_less, res_zero  in  1 each  ALU flags, valid with res_valid
- res_imm  in  32  sign-extended immediate, valid with res_valid
- res_rs1  in  32  rs1 value, valid with res_valid
- trap_valid  in  1  trap/interrupt redirect request
- trap_pc  in  32  trap target, valid with trap_valid
- taken  out  1  one-cycle pulse: the resolved instruction redirected the PC
- retired_cnt  out  32  count of resolved instructions, wraps

## Operation
- States: FETCH, ISSUE, RESOLVE, DRAIN.
- After reset: state FETCH, pc=RESET_PC, imem_req=0, instr_valid=0, taken=0, retired_cnt=0, instr=0, instr_pc=0.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack: latch imem_rdata and pc into instr and instr_pc, drop imem_req, go to ISSUE.
- ISSUE: instr_valid=1. On instr_ready, drop instr_valid and go to RESOLVE.
- RESOLVE: wait for res_valid, then compute the condition:
  - 000 and 011: no redirect.
  - 001: take the PC+imm target.
  - 010: take the rs1+imm target.
  - 100: redirect if zero. 101: redirect if ~zero.
  - 110: redirect if less. 111: redirect if ~less.
- Next PC:
  - PC+imm target is instr_pc+res_imm, computed mod 2^32.
  - rs1+imm target is (res_rs1+res_imm) & ~32'h1.
  - With no redirect, next pc is instr_pc+4.
  - taken=1 for one cycle only when the target differs from the fall-through choice, i.e. branch taken or jump.
  - retired_cnt increments; the next state is FETCH.
- Trap (highest priority, sampled each cycle):
  - pc is loaded with trap_pc.
  - instr_valid is cleared.
  - The resolution in the same cycle is discarded, but retired_cnt still counts it if res_valid=1.
  - From FETCH with imem_req=1 and no imem_ack in that cycle: go to DRAIN and keep imem_req=1 with the old address until ack (the bus cannot cancel). Discard the data, then go to FETCH.
  - From FETCH when imem_ack arrives in the trap cycle: data discarded, go to FETCH.
  - Otherwise: go to FETCH.
- res_valid outside RESOLVE is ignored. trap_valid during DRAIN updates pc again; the last trap wins.

## Timing
- Minimum instruction period is 4 cycles: FETCH with 1-cycle ack, ISSUE with immediate ready, RESOLVE with immediate res_valid, and back to FETCH.
- imem_req is registered and deasserts the cycle after ack.
- instr/instr_pc are registered and stable for the whole of ISSUE.
- taken and the pc update appear the cycle after res_valid.
- Reset asserted mid-operation immediately forces reset values. A pending memory read is abandoned; the memory side must also be reset.

## Structure
- Shared core package:
  - branch code constants (BR_NONE, BR_JAL, BR_JALR, BR_BEQ, BR_BNE, BR_BLT, BR_BGE)
  - fetch state enum
- One combinational sub-module, next_pc_sel: takes branch code, flags, instr_pc, imm and rs1; returns next_pc and taken. The FSM stays in the top module.

## Test plan
- Reset release, ack latency 1, ready immediate, res 000 → fetches at 0x0, 0x4, 0x8; retired_cnt=3 after three resolutions; taken never 1.
- beq with zero=1, instr_pc=0x100, imm=0x20 → next imem_addr=0x120, taken pulse. bne with zero=1 → 0x104, no taken.
- jalr with rs1=0x2001, imm=0x10 → next imem_addr=0x2010. jal with instr_pc=0x8, imm=-8 → 0x0.
- Trap at trap_pc=0x80 two cycles into a 5-cycle ack latency → imem_req held at the old address until ack, data not offered, then fetch at 0x80.
- Backpressure: instr_ready low 3 cycles → instr and instr_pc held constant. A res_valid pulse during ISSUE is ignored.
- rstn pulsed low in RESOLVE → all outputs return to reset values, and the first fetch after release is at RESET_PC.
